// File: rtl/decoder_pkg.sv
// Shared CSR types and the read-modify-write helper used by every CSR block
// on the core's CSR bus.
package decoder_pkg;

  typedef logic [11:0] csr_addr_t;
  typedef logic [4:0]  r;
  typedef logic [31:0] word;

  // Encoding matches the funct3 field of the Zicsr instructions
  typedef enum logic [2:0] {
    CSR_NONE = 3'b000,
    CSRRW    = 3'b001,
    CSRRS    = 3'b010,
    CSRRC    = 3'b011,
    CSR_RSV  = 3'b100,
    CSRRWI   = 3'b101,
    CSRRSI   = 3'b110,
    CSRRCI   = 3'b111
  } csr_op_t;

  typedef struct packed {
    logic we;
    word  wdata;
  } csr_wr_t;

  // Set/clear with a zero operand is a pure read, so we stays low for it
  function automatic csr_wr_t csr_apply(csr_op_t op, word old, word rs1, r zimm);
    word     opnd;
    csr_wr_t res;
    opnd      = op[2] ? {27'd0, zimm} : rs1;
    res.we    = 1'b0;
    res.wdata = old;
    case (op)
      CSRRW, CSRRWI: begin res.we = 1'b1;  res.wdata = opnd;        end
      CSRRS, CSRRSI: begin res.we = |opnd; res.wdata = old | opnd;  end
      CSRRC, CSRRCI: begin res.we = |opnd; res.wdata = old & ~opnd; end
      default: ;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_counter_cell.sv
// One event counter channel. A CSR write to either half wins over the
// hardware increment; wrap pulses on the edge where all-ones rolls to zero.
module csr_counter_cell
  import decoder_pkg::*;
#(
  parameter int CntWidth = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                lo_wr,
  input  logic                hi_wr,
  input  word                 wdata,
  input  logic                event_in,
  input  logic                inhibit,
  output logic [CntWidth-1:0] value,
  output logic                wrap
);

  logic inc;

  assign inc  = event_in && !inhibit && !lo_wr && !hi_wr;
  assign wrap = inc && (&value);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     value <= '0;
    else if (lo_wr) value[31:0] <= wdata;
    else if (hi_wr) value[CntWidth-1:32] <= wdata[CntWidth-33:0];
    else if (inc)   value <= value + CntWidth'(1);
  end

endmodule

// File: rtl/csr_counter_bank.sv
// Bank of event counters exposed as lo/hi CSR pairs, with inhibit, sticky
// overflow and a registered overflow interrupt.
module csr_counter_bank
  import decoder_pkg::*;
#(
  parameter int                     NumCounters  = 4,
  parameter int                     CntWidth     = 64,
  parameter logic [11:0]            BaseAddrLo   = 12'hB03,
  parameter logic [11:0]            BaseAddrHi   = 12'hB83,
  parameter logic [11:0]            InhibitAddr  = 12'h320,
  parameter logic [11:0]            OvfAddr      = 12'h7C0,
  parameter logic [NumCounters-1:0] InhibitReset = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   csr_enable,
  input  csr_addr_t              csr_addr,
  input  csr_op_t                csr_op,
  input  r                       rs1_zimm,
  input  word                    rs1_data,
  input  logic [NumCounters-1:0] event_in,
  output word                    out,
  output logic                   ovf_irq
);

  logic [NumCounters-1:0]               lo_hit, hi_hit, wrap, inhibit, ovf, ovf_sw;
  logic [NumCounters-1:0][CntWidth-1:0] cnt_val;
  logic                                 inh_hit, ovf_hit, any_hit, eff;
  csr_wr_t                              wr;

  assign inh_hit = (csr_addr == InhibitAddr);
  assign ovf_hit = (csr_addr == OvfAddr);
  assign any_hit = |{lo_hit, hi_hit, inh_hit, ovf_hit};

  // Address map is assumed non-overlapping, so OR-ing the hits is a mux
  always_comb begin
    out = '0;
    for (int k = 0; k < NumCounters; k++) begin
      if (lo_hit[k]) out |= cnt_val[k][31:0];
      if (hi_hit[k]) out[CntWidth-33:0] |= cnt_val[k][CntWidth-1:32];
    end
    if (inh_hit) out[NumCounters-1:0] |= inhibit;
    if (ovf_hit) out[NumCounters-1:0] |= ovf;
  end

  assign wr  = csr_apply(csr_op, out, rs1_data, rs1_zimm);
  assign eff = csr_enable && any_hit && wr.we;

  genvar k;
  generate
    for (k = 0; k < NumCounters; k++) begin : g_cnt
      assign lo_hit[k] = (csr_addr == BaseAddrLo + 12'(k));
      assign hi_hit[k] = (csr_addr == BaseAddrHi + 12'(k));

      csr_counter_cell #(.CntWidth(CntWidth)) u_cell (
        .clk      (clk),
        .reset    (reset),
        .lo_wr    (eff && lo_hit[k]),
        .hi_wr    (eff && hi_hit[k]),
        .wdata    (wr.wdata),
        .event_in (event_in[k]),
        .inhibit  (inhibit[k]),
        .value    (cnt_val[k]),
        .wrap     (wrap[k])
      );
    end
  endgenerate

  // Hardware wrap is OR-ed in after the software value so it wins a same-cycle clear
  assign ovf_sw = (eff && ovf_hit) ? wr.wdata[NumCounters-1:0] : ovf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inhibit <= InhibitReset;
      ovf     <= '0;
      ovf_irq <= 1'b0;
    end else begin
      if (eff && inh_hit) inhibit <= wr.wdata[NumCounters-1:0];
      ovf     <= ovf_sw | wrap;
      ovf_irq <= |ovf;
    end
  end

endmodule

// File: tb/tb_csr_counter_bank.sv
// Randomised and directed bench for csr_counter_bank; a reference model
// predicts each cycle's read data and irq, and a monitor checks them.
module tb_csr_counter_bank;
  import decoder_pkg::*;

  localparam int          N   = 4;
  localparam logic [11:0] LO  = 12'hB03;
  localparam logic [11:0] HI  = 12'hB83;
  localparam logic [11:0] INH = 12'h320;
  localparam logic [11:0] OVF = 12'h7C0;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  logic      en = 1'b0;
  csr_addr_t addr = 12'h123;
  csr_op_t   op = CSRRS;
  word       rs1 = '0;
  r          zimm = '0;
  logic [N-1:0] ev = '0;
  word       out;
  logic      irq;

  always #5 clk = ~clk;

  csr_counter_bank #(.NumCounters(N), .CntWidth(64)) dut (
    .clk(clk), .reset(rst_n), .csr_enable(en), .csr_addr(addr), .csr_op(op),
    .rs1_zimm(zimm), .rs1_data(rs1), .event_in(ev), .out(out), .ovf_irq(irq)
  );

  typedef struct {
    word   out;
    logic  irq;
    string name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic tb_vld = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  longint unsigned m_cnt[N];
  logic [N-1:0]    m_inh, m_ovf;
  logic            m_irq;

  function automatic void m_reset();
    for (int k = 0; k < N; k++) m_cnt[k] = 0;
    m_inh = '0; m_ovf = '0; m_irq = 1'b0;
  endfunction

  function automatic bit m_hit(csr_addr_t a);
    for (int k = 0; k < N; k++)
      if (a == LO + 12'(k) || a == HI + 12'(k)) return 1'b1;
    return (a == INH) || (a == OVF);
  endfunction

  function automatic word m_read(csr_addr_t a);
    for (int k = 0; k < N; k++) begin
      if (a == LO + 12'(k)) return m_cnt[k][31:0];
      if (a == HI + 12'(k)) return m_cnt[k][63:32];
    end
    if (a == INH) return {28'd0, m_inh};
    if (a == OVF) return {28'd0, m_ovf};
    return '0;
  endfunction

  function automatic void m_step(logic e, csr_addr_t a, logic [2:0] o, word d, r z, logic [N-1:0] v);
    word old, opnd, nv;
    bit  wk, eff;
    logic [N-1:0] wraps;
    logic prev_or;
    old  = m_read(a);
    opnd = o[2] ? {27'd0, z} : d;
    wk = 0; nv = old;
    case (o[1:0])
      2'b01: begin wk = 1;         nv = opnd;        end
      2'b10: begin wk = (opnd != 0); nv = old | opnd;  end
      2'b11: begin wk = (opnd != 0); nv = old & ~opnd; end
      default: wk = 0;
    endcase
    eff = e && m_hit(a) && wk;
    wraps = '0;
    prev_or = |m_ovf;
    for (int k = 0; k < N; k++) begin
      if (eff && a == LO + 12'(k))      m_cnt[k] = {m_cnt[k][63:32], nv};
      else if (eff && a == HI + 12'(k)) m_cnt[k] = {nv, m_cnt[k][31:0]};
      else if (v[k] && !m_inh[k]) begin
        m_cnt[k] = m_cnt[k] + 1;
        if (m_cnt[k] == 0) wraps[k] = 1'b1;
      end
    end
    m_ovf = ((eff && a == OVF) ? nv[N-1:0] : m_ovf) | wraps;
    if (eff && a == INH) m_inh = nv[N-1:0];
    m_irq = prev_or;
  endfunction

  // Monitor: every presented cycle is compared against the oldest prediction
  always @(negedge clk) begin
    if (tb_vld) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty out=%h irq=%b", out, irq);
      end else begin
        mon_e = sb.pop_front();
        if (out !== mon_e.out) begin
          errors++;
          $display("FAIL %s out got %h exp %h", mon_e.name, out, mon_e.out);
        end
        checks++;
        if (irq !== mon_e.irq) begin
          errors++;
          $display("FAIL %s ovf_irq got %b exp %b", mon_e.name, irq, mon_e.irq);
        end
      end
    end
  end

  task automatic cyc(logic e, csr_addr_t a, logic [2:0] o, word d, r z, logic [N-1:0] v, string nm);
    exp_t x;
    en = e; addr = a; op = csr_op_t'(o); rs1 = d; zimm = z; ev = v;
    x.out = m_read(a); x.irq = m_irq; x.name = nm;
    sb.push_back(x);
    tb_vld = 1'b1;
    @(posedge clk);
    if (rst_n) m_step(e, a, o, d, z, v);
    #1;
  endtask

  task automatic idle(logic [N-1:0] v);
    cyc(1'b0, 12'h123, 3'b010, '0, '0, v, "idle");
  endtask

  task automatic rd(csr_addr_t a, string nm);
    cyc(1'b1, a, 3'b010, '0, '0, '0, nm);
  endtask

  task automatic wr(csr_addr_t a, word d, logic [N-1:0] v);
    cyc(1'b1, a, 3'b001, d, '0, v, "write");
  endtask

  initial begin
    csr_addr_t ra;
    m_reset();
    @(posedge clk); #1;
    rd(LO, "reset_lo0");
    rd(OVF, "reset_ovf");
    rst_n = 1'b1;

    repeat (10) idle(4'b0001);
    rd(LO, "cnt0_lo_10"); rd(HI, "cnt0_hi_0");
    for (int k = 1; k < N; k++) rd(LO + 12'(k), "cnt_other_0");
    rd(12'h123, "unmapped");

    wr(LO + 1, 32'hFFFF_FFFF, '0);
    idle(4'b0010);
    rd(LO + 1, "cnt1_carry_lo"); rd(HI + 1, "cnt1_carry_hi"); rd(OVF, "carry_no_ovf");

    wr(HI + 2, 32'hFFFF_FFFF, '0); wr(LO + 2, 32'hFFFF_FFFE, '0);
    idle(4'b0100); idle(4'b0100);
    rd(LO + 2, "cnt2_wrap_lo"); rd(OVF, "ovf_bit2"); rd(OVF, "irq_delayed");

    wr(LO, 32'd5, 4'b0001);
    rd(LO, "write_beats_inc");
    cyc(1'b1, LO, 3'b010, '0, '0, 4'b0001, "rs0_pre_inc");
    rd(LO, "rs0_post_inc");

    cyc(1'b1, INH, 3'b110, '0, 5'b00010, 4'b0010, "inh_set");
    repeat (5) idle(4'b0010);
    rd(LO + 1, "inhibited_cnt1"); rd(INH, "inh_read");

    wr(HI, 32'hFFFF_FFFF, '0); wr(LO, 32'hFFFF_FFFF, '0);
    idle(4'b0001);
    wr(HI, 32'hFFFF_FFFF, '0); wr(LO, 32'hFFFF_FFFF, '0);
    cyc(1'b1, OVF, 3'b011, 32'd1, '0, 4'b0001, "clr_vs_wrap");
    rd(OVF, "ovf_hw_wins");
    cyc(1'b1, OVF, 3'b111, '0, 5'b00101, '0, "ovf_clri");
    rd(OVF, "ovf_cleared");

    for (int i = 0; i < 600; i++) begin
      int sel, ds;
      word d;
      sel = $urandom_range(0, 11);
      case (sel)
        8:  ra = INH;
        9:  ra = OVF;
        10: ra = 12'h123;
        11: ra = LO + 12'(N);
        default: ra = (sel < 4) ? LO + 12'(sel) : HI + 12'(sel - 4);
      endcase
      ds = $urandom_range(0, 3);
      d = (ds == 0) ? 32'd0 : (ds == 1) ? 32'hFFFF_FFFF : (ds == 2) ? 32'hFFFF_FFFE : $urandom;
      cyc($urandom_range(0, 3) != 0, ra, 3'($urandom_range(0, 7)), d,
          5'($urandom_range(0, 31)), N'($urandom), "rand");
    end

    repeat (4) idle(4'b1111);
    rst_n = 1'b0;
    m_reset();
    cyc(1'b0, LO + 3, 3'b010, '0, '0, 4'b1111, "async_reset");
    rst_n = 1'b1;
    idle(4'b1111);
    rd(LO, "first_after_reset");

    tb_vld = 1'b0;
    for (int t = 0; t < 10 && sb.size() != 0; t++) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
